// File: rtl/opb_master_pkg.sv
// opb_master_pkg: shared types for the single-beat OPB master.
// FSM state encoding, response status codes and default bus widths.
package opb_master_pkg;

    localparam int OPB_AW = 32;
    localparam int OPB_DW = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_XFER    = 3'd2,
        S_BACKOFF = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK    = 2'b00;
    localparam status_t ST_ERR   = 2'b01;
    localparam status_t ST_TOUT  = 2'b10;
    localparam status_t ST_RETRY = 2'b11;

endpackage

// File: rtl/opb_master_single_if.sv
// opb_master_single_if: OPB master bus signals plus the user command/response
// port; the master modport is the initiator's view, slave is the far side.
interface opb_master_single_if
    import opb_master_pkg::*;
#(
    parameter int AW = OPB_AW,
    parameter int DW = OPB_DW
);
    logic              M_request;
    logic              M_busLock;
    logic              M_select;
    logic              M_RNW;
    logic [0:DW/8-1]   M_BE;
    logic              M_seqAddr;
    logic [0:AW-1]     M_ABus;
    logic [0:DW-1]     M_DBus;
    logic              OPB_MGrant;
    logic              OPB_xferAck;
    logic              OPB_errAck;
    logic              OPB_retry;
    logic              OPB_timeout;
    logic [0:DW-1]     OPB_DBus;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rnw;
    logic [0:AW-1]     cmd_addr;
    logic [0:DW-1]     cmd_wdata;
    logic [0:DW/8-1]   cmd_be;
    logic              rsp_valid;
    logic [0:DW-1]     rsp_rdata;
    logic [1:0]        rsp_status;

    modport master (
        output M_request, M_busLock, M_select, M_RNW,
        output M_BE, M_seqAddr, M_ABus, M_DBus,
        input  OPB_MGrant, OPB_xferAck, OPB_errAck,
        input  OPB_retry, OPB_timeout, OPB_DBus,
        input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_be,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status
    );

    modport slave (
        input  M_request, M_busLock, M_select, M_RNW,
        input  M_BE, M_seqAddr, M_ABus, M_DBus,
        output OPB_MGrant, OPB_xferAck, OPB_errAck,
        output OPB_retry, OPB_timeout, OPB_DBus,
        output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_be,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status
    );

endinterface

// File: rtl/opb_master_single.sv
// opb_master_single: single-beat OPB initiator with retry and error status.
// Define OPB_MASTER_WATCHDOG_EN to add an XFER watchdog (C_WDOG_CYCLES).
module opb_master_single
    import opb_master_pkg::*;
#(
    parameter int    C_OPB_AWIDTH  = OPB_AW,
    parameter int    C_OPB_DWIDTH  = OPB_DW,
    parameter int    C_MAX_RETRY   = 4,
    parameter int    C_WDOG_CYCLES = 64,
    parameter string C_FAMILY      = "virtex6"
) (
    input logic                 OPB_Clk,
    input logic                 OPB_Rst_n,
    opb_master_single_if.master bus
);

    localparam int BW = C_OPB_DWIDTH / 8;
    localparam logic [4:0] MAX_R = 5'(C_MAX_RETRY);

    state_t state, state_n;
    logic [4:0] retry_q, retry_n;
    logic accept, wdog_hit;

    logic                    rnw_q;
    logic [0:C_OPB_AWIDTH-1] addr_q;
    logic [0:C_OPB_DWIDTH-1] wdata_q;
    logic [0:BW-1]           be_q;

    status_t                 st_n;
    logic [0:C_OPB_DWIDTH-1] rd_n;

    logic req_q, sel_q, mrnw_q, rdy_q, rspv_q;
    logic req_d, sel_d, mrnw_d, rdy_d, rspv_d;
    logic [0:C_OPB_AWIDTH-1] abus_q, abus_d;
    logic [0:C_OPB_DWIDTH-1] dbus_q, dbus_d;
    logic [0:C_OPB_DWIDTH-1] rd_q, rd_d;
    logic [0:BW-1]           mbe_q, mbe_d;
    status_t                 st_q, st_d;

    assign accept = bus.cmd_valid & rdy_q;

`ifdef OPB_MASTER_WATCHDOG_EN
    localparam int WW = $clog2(C_WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(C_WDOG_CYCLES - 1);
    logic [WW-1:0] wdog_q;

    // Held at zero outside XFER, so it restarts on every tenure.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n)
            wdog_q <= '0;
        else if (state != S_XFER)
            wdog_q <= '0;
        else
            wdog_q <= wdog_q + WW'(1);
    end

    assign wdog_hit = (state == S_XFER) && (wdog_q == WDOG_LAST);
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state   <= S_IDLE;
            retry_q <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            req_q   <= 1'b0;
            sel_q   <= 1'b0;
            mrnw_q  <= 1'b0;
            rdy_q   <= 1'b0;
            rspv_q  <= 1'b0;
            abus_q  <= '0;
            dbus_q  <= '0;
            mbe_q   <= '0;
            st_q    <= ST_OK;
            rd_q    <= '0;
        end else begin
            state   <= state_n;
            retry_q <= retry_n;
            if (accept) begin
                rnw_q   <= bus.cmd_rnw;
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
                be_q    <= bus.cmd_be;
            end
            req_q  <= req_d;
            sel_q  <= sel_d;
            mrnw_q <= mrnw_d;
            rdy_q  <= rdy_d;
            rspv_q <= rspv_d;
            abus_q <= abus_d;
            dbus_q <= dbus_d;
            mbe_q  <= mbe_d;
            st_q   <= st_d;
            rd_q   <= rd_d;
        end
    end

    always_comb begin
        state_n = state;
        retry_n = retry_q;
        st_n    = ST_OK;
        rd_n    = '0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_REQ;
                    retry_n = '0;
                end
            end
            S_REQ: begin
                if (bus.OPB_MGrant)
                    state_n = S_XFER;
            end
            S_XFER: begin
                if (bus.OPB_errAck) begin
                    state_n = S_RESP;
                    st_n    = ST_ERR;
                end else if (bus.OPB_xferAck) begin
                    state_n = S_RESP;
                    rd_n    = rnw_q ? bus.OPB_DBus : '0;
                end else if (bus.OPB_retry) begin
                    retry_n = retry_q + 5'd1;
                    if (retry_n > MAX_R) begin
                        state_n = S_RESP;
                        st_n    = ST_RETRY;
                    end else begin
                        state_n = S_BACKOFF;
                    end
                end else if (bus.OPB_timeout || wdog_hit) begin
                    state_n = S_RESP;
                    st_n    = ST_TOUT;
                end
            end
            S_BACKOFF: state_n = S_REQ;
            S_RESP:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they track the state
    // register exactly and stay glitch-free on the OR-bus.
    always_comb begin
        req_d  = (state_n == S_REQ);
        sel_d  = (state_n == S_XFER);
        rdy_d  = (state_n == S_IDLE);
        rspv_d = (state_n == S_RESP);
        mrnw_d = sel_d & rnw_q;
        abus_d = sel_d ? addr_q : '0;
        mbe_d  = sel_d ? be_q : '0;
        dbus_d = (sel_d && !rnw_q) ? wdata_q : '0;
        st_d   = rspv_d ? st_n : ST_OK;
        rd_d   = rspv_d ? rd_n : '0;
    end

    assign bus.M_request  = req_q;
    assign bus.M_busLock  = 1'b0;
    assign bus.M_select   = sel_q;
    assign bus.M_RNW      = mrnw_q;
    assign bus.M_BE       = mbe_q;
    assign bus.M_seqAddr  = 1'b0;
    assign bus.M_ABus     = abus_q;
    assign bus.M_DBus     = dbus_q;
    assign bus.cmd_ready  = rdy_q;
    assign bus.rsp_valid  = rspv_q;
    assign bus.rsp_rdata  = rd_q;
    assign bus.rsp_status = st_q;

endmodule

// File: tb/tb_opb_master_single.sv
// tb_opb_master_single: directed bench with a scripted OPB slave/arbiter and
// a per-command model of status, data, latency and bus tenures.
module tb_opb_master_single;

    localparam int WDOG = 8;
    localparam int MAXR = 4;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_RTY  = 2;
    localparam int K_TO   = 3;
    localparam int K_EA   = 4;
    localparam int K_NONE = 5;

    typedef struct {
        int          gw;
        int          wt;
        int          kind;
        logic [31:0] data;
    } ten_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    opb_master_single_if bus ();

    opb_master_single #(
        .C_MAX_RETRY   (MAXR),
        .C_WDOG_CYCLES (WDOG)
    ) dut (
        .OPB_Clk   (clk),
        .OPB_Rst_n (rst_n),
        .bus       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    ten_t scr[$];
    int   tidx  = 0;
    logic stray = 1'b0;

    logic        exp_rnw;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_st, exp_rd;
    int          exp_lat, exp_ten, exp_sel;

    logic in_txn = 1'b0;
    logic rsp_seen = 1'b0;
    logic prev_sel = 1'b0;
    int   rsp_cnt = 0;
    int   mon_lat, mon_ten, mon_sel, mon_gaps;
    logic [31:0] last_st, last_rd;
    int   last_lat, last_sel, last_gaps, last_ten;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic add_ten(input int gw, input int wt, input int kind,
                           input logic [31:0] data);
        ten_t t;
        t.gw = gw;
        t.wt = wt;
        t.kind = kind;
        t.data = data;
        scr.push_back(t);
    endtask

    // Transaction-level model: walk the slave script applying the response
    // priority and retry limit to get status, data and cycle accounting.
    function automatic void model(input logic rnw);
        int r = 0;
        int xc;
        logic done = 1'b0;
        exp_st = 0;
        exp_rd = 0;
        exp_lat = 2;
        exp_ten = 0;
        exp_sel = 0;
        for (int i = 0; i < scr.size() && !done; i++) begin
            exp_ten++;
            if (i > 0) exp_lat++;
            exp_lat += scr[i].gw + 1;
            xc = (scr[i].kind == K_NONE) ? WDOG : scr[i].wt + 1;
            exp_sel += xc;
            exp_lat += xc;
            done = 1'b1;
            case (scr[i].kind)
                K_ACK: begin
                    exp_st = 0;
                    exp_rd = rnw ? scr[i].data : 32'h0;
                end
                K_ERR, K_EA: exp_st = 1;
                K_TO, K_NONE: exp_st = 2;
                default: begin
                    r++;
                    if (r > MAXR) exp_st = 3;
                    else done = 1'b0;
                end
            endcase
        end
    endfunction

    // Scripted arbiter and slave, acting just after each falling edge.
    initial begin
        int rc = 0;
        int sc = 0;
        forever begin
            @(negedge clk);
            #1;
            bus.OPB_MGrant  = stray;
            bus.OPB_xferAck = 1'b0;
            bus.OPB_errAck  = 1'b0;
            bus.OPB_retry   = 1'b0;
            bus.OPB_timeout = 1'b0;
            bus.OPB_DBus    = '0;
            if (bus.M_request) rc++;
            else rc = 0;
            if (bus.M_select) sc++;
            else sc = 0;
            if (tidx < scr.size()) begin
                if (bus.M_request && rc > scr[tidx].gw)
                    bus.OPB_MGrant = 1'b1;
                if (bus.M_select && sc > scr[tidx].wt &&
                    scr[tidx].kind != K_NONE) begin
                    bus.OPB_DBus = scr[tidx].data;
                    case (scr[tidx].kind)
                        K_ACK: bus.OPB_xferAck = 1'b1;
                        K_ERR: bus.OPB_errAck = 1'b1;
                        K_RTY: bus.OPB_retry = 1'b1;
                        K_TO:  bus.OPB_timeout = 1'b1;
                        default: begin
                            bus.OPB_errAck  = 1'b1;
                            bus.OPB_xferAck = 1'b1;
                        end
                    endcase
                    tidx++;
                    sc = 0;
                end
            end
        end
    end

    // Compare process: checks the outputs on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!bus.M_select)
                chk("or_bus_idle",
                    {31'h0, (|bus.M_ABus) | (|bus.M_DBus) |
                            (|bus.M_BE) | bus.M_RNW}, 32'h0);
            if (bus.M_select && in_txn) begin
                chk("m_abus", bus.M_ABus, exp_addr);
                chk("m_be", bus.M_BE, exp_be);
                chk("m_rnw", bus.M_RNW, exp_rnw);
                chk("m_dbus", bus.M_DBus, exp_rnw ? 32'h0 : exp_wdata);
                chk("req_sel_excl", bus.M_request, 0);
            end
            chk("tieoffs", {bus.M_busLock, bus.M_seqAddr}, 0);
            if (!in_txn) begin
                chk("bus_quiet",
                    {bus.M_request, bus.M_select, bus.rsp_valid}, 0);
            end else begin
                mon_lat++;
                if (bus.M_select && !prev_sel) mon_ten++;
                if (bus.M_select) mon_sel++;
                if (!bus.M_request && !bus.M_select && !bus.rsp_valid)
                    mon_gaps++;
                chk("busy_not_ready", bus.cmd_ready, 0);
                if (bus.rsp_valid) begin
                    chk("rsp_status", bus.rsp_status, exp_st);
                    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
                    chk("latency", mon_lat, exp_lat);
                    chk("tenures", mon_ten, exp_ten);
                    chk("backoffs", mon_gaps, exp_ten - 1);
                    chk("sel_cycles", mon_sel, exp_sel);
                    last_st   = 32'(bus.rsp_status);
                    last_rd   = bus.rsp_rdata;
                    last_lat  = mon_lat;
                    last_sel  = mon_sel;
                    last_gaps = mon_gaps;
                    last_ten  = mon_ten;
                    rsp_cnt++;
                    in_txn   = 1'b0;
                    rsp_seen = 1'b1;
                end
            end
            prev_sel = bus.M_select;
        end
    end

    task automatic issue(input logic rnw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        tidx = 0;
        model(rnw);
        exp_rnw = rnw;
        exp_addr = a;
        exp_wdata = wd;
        exp_be = be;
        @(negedge clk);
        #1;
        chk("ready_idle", bus.cmd_ready, 1);
        bus.cmd_rnw   = rnw;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bus.cmd_be    = be;
        bus.cmd_valid = 1'b1;
        mon_lat  = 1;
        mon_ten  = 0;
        mon_sel  = 0;
        mon_gaps = 0;
        rsp_seen = 1'b0;
        in_txn   = 1'b1;
    endtask

    task automatic wait_rsp(input int budget);
        for (int k = 0; k < budget && !rsp_seen; k++) begin
            @(negedge clk);
            #1;
        end
        chk("rsp_arrived", rsp_seen, 1);
        in_txn = 1'b0;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic rnw, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        issue(rnw, a, wd, be);
        wait_rsp(200);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        int c0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_rnw     = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_wdata   = '0;
        bus.cmd_be      = '0;
        bus.OPB_MGrant  = 1'b0;
        bus.OPB_xferAck = 1'b0;
        bus.OPB_errAck  = 1'b0;
        bus.OPB_retry   = 1'b0;
        bus.OPB_timeout = 1'b0;
        bus.OPB_DBus    = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_request", bus.M_request, 0);
        chk("rst_select", bus.M_select, 0);
        chk("rst_abus", bus.M_ABus, 0);
        chk("rst_dbus", bus.M_DBus, 0);
        chk("rst_ready", bus.cmd_ready, 0);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_status}, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_reset", bus.cmd_ready, 1);

        scr.delete();
        add_ten(0, 0, K_ACK, 32'h5A5A5A5A);
        run_cmd(1'b0, 32'h01188500, 32'hDEADBEEF, 4'hF);
        chk("wr_status_lit", last_st, 32'h0);
        chk("wr_rdata_lit", last_rd, 32'h0);
        chk("wr_latency_lit", last_lat, 4);

        scr.delete();
        add_ten(0, 3, K_ACK, 32'h12345678);
        run_cmd(1'b1, 32'h01188504, 32'h0, 4'hF);
        chk("rd_rdata_lit", last_rd, 32'h12345678);
        chk("rd_sel_lit", last_sel, 4);
        chk("rd_status_lit", last_st, 32'h0);

        scr.delete();
        for (int i = 0; i < 5; i++) add_ten(0, 0, K_RTY, 32'hAAAA5555);
        run_cmd(1'b1, 32'h01188508, 32'h0, 4'hF);
        chk("rty_status_lit", last_st, 32'h3);
        chk("rty_rdata_lit", last_rd, 32'h0);
        chk("rty_backoff_lit", last_gaps, 4);
        chk("rty_tenure_lit", last_ten, 5);

        scr.delete();
        add_ten(1, 2, K_EA, 32'hCAFEF00D);
        run_cmd(1'b1, 32'h0118850C, 32'h0, 4'hF);
        chk("errack_status_lit", last_st, 32'h1);
        chk("errack_rdata_lit", last_rd, 32'h0);

        scr.delete();
        add_ten(2, 1, K_TO, 32'h0);
        run_cmd(1'b0, 32'h00000010, 32'h0BADF00D, 4'b0011);
        chk("tout_status_lit", last_st, 32'h2);

        scr.delete();
        add_ten(1, 0, K_RTY, 32'h0);
        add_ten(0, 2, K_RTY, 32'h0);
        add_ten(3, 1, K_ACK, 32'h87654321);
        run_cmd(1'b1, 32'hFFFFFFFC, 32'h0, 4'b1000);
        chk("rty_ack_status_lit", last_st, 32'h0);
        chk("rty_ack_rdata_lit", last_rd, 32'h87654321);
        chk("rty_ack_backoff_lit", last_gaps, 2);

        scr.delete();
        add_ten(0, 0, K_ERR, 32'h0);
        run_cmd(1'b0, 32'h00000020, 32'h11112222, 4'b0110);
        chk("err_status_lit", last_st, 32'h1);

        @(negedge clk);
        #1;
        stray = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        stray = 1'b0;
        chk("stray_grant_sel", bus.M_select, 0);
        chk("stray_grant_ready", bus.cmd_ready, 1);

`ifdef OPB_MASTER_WATCHDOG_EN
        scr.delete();
        add_ten(0, 0, K_NONE, 32'h0);
        run_cmd(1'b1, 32'h00000040, 32'h0, 4'hF);
        chk("wdog_status_lit", last_st, 32'h2);
        chk("wdog_sel_lit", last_sel, 8);
`endif

        scr.delete();
        add_ten(0, 20, K_ACK, 32'h0);
        issue(1'b0, 32'h00000080, 32'h13579BDF, 4'hF);
        for (int k = 0; k < 20 && !bus.M_select; k++) begin
            @(negedge clk);
            #1;
        end
        chk("sel_before_reset", bus.M_select, 1);
        repeat (2) @(negedge clk);
        #1;
        c0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_select", bus.M_select, 0);
        chk("mid_rst_request", bus.M_request, 0);
        chk("mid_rst_abus", bus.M_ABus, 0);
        in_txn = 1'b0;
        scr.delete();
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_mid_rst", bus.cmd_ready, 1);
        chk("no_rsp_discarded", rsp_cnt, c0);

        scr.delete();
        add_ten(0, 1, K_ACK, 32'h0);
        run_cmd(1'b0, 32'h00000084, 32'h2468ACE0, 4'b0101);
        chk("recover_status_lit", last_st, 32'h0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
